// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of the requester-side and memory-side signals of
// mem_arbiter.
//
// Requester side (one lane per port, port 0 = I-cache, port 1 = D-cache):
//   req_valid / req_r0w1 / req_addr / req_wdata : request, held until req_ready
//   req_ready / req_rdata                       : completion pulse + read block
// Memory side (towards the next level):
//   mem_valid / mem_r0w1 / mem_addr / mem_wdata : request, stable until mem_ready
//   mem_ready / mem_rdata                       : one-cycle completion + read block
//
// Modports:
//   slave  : the arbiter (consumes requests, drives the memory request)
//   master : the surrounding environment (caches + next-level memory)
interface mem_arbiter_if #(
  parameter int BW_ADDRESS = 32,
  parameter int BW_BLOCK   = 128,
  parameter int NUM_PORT   = 2
);

  logic [NUM_PORT-1:0]                 req_valid;
  logic [NUM_PORT-1:0]                 req_r0w1;
  logic [NUM_PORT-1:0][BW_ADDRESS-1:0] req_addr;
  logic [NUM_PORT-1:0][BW_BLOCK-1:0]   req_wdata;
  logic [NUM_PORT-1:0]                 req_ready;
  logic [NUM_PORT-1:0][BW_BLOCK-1:0]   req_rdata;

  logic                                mem_valid;
  logic                                mem_r0w1;
  logic [BW_ADDRESS-1:0]               mem_addr;
  logic [BW_BLOCK-1:0]                 mem_wdata;
  logic                                mem_ready;
  logic [BW_BLOCK-1:0]                 mem_rdata;

  modport slave (
    input  req_valid, req_r0w1, req_addr, req_wdata, mem_ready, mem_rdata,
    output req_ready, req_rdata, mem_valid, mem_r0w1, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_r0w1, req_addr, req_wdata, mem_ready, mem_rdata,
    input  req_ready, req_rdata, mem_valid, mem_r0w1, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one next-level memory port between NUM_PORT cache
// requesters (port 0 = I-cache, port 1 = D-cache). One transaction is in
// flight at a time; an IDLE cycle always separates two transactions.
//
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (requester lanes + next-level request)
//
// Parameters:
//   BW_ADDRESS : request address width
//   BW_BLOCK   : data width of one transfer (one cache block)
//   NUM_PORT   : number of requesters, 2..8
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN : when defined, arbitration is round-robin starting
//                            at a pointer that moves to winner+1 on each grant.
//                            When undefined, lowest-index requester wins and no
//                            pointer exists.
module mem_arbiter #(
  parameter int BW_ADDRESS = 32,
  parameter int BW_BLOCK   = 128,
  parameter int NUM_PORT   = 2
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam int GW = $clog2(NUM_PORT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         win;
  logic                  any_req;

  logic                  mem_valid_q;
  logic                  mem_r0w1_q;
  logic [BW_ADDRESS-1:0] mem_addr_q;
  logic [BW_BLOCK-1:0]   mem_wdata_q;

  assign any_req = |bus.req_valid;

  // ---------------------------------------------------------------------------
  // Winner selection (only consumed in IDLE)
  // ---------------------------------------------------------------------------
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] rr_next;
  logic [GW:0]   cand;
  logic          found;

  // Scan ports starting at rr_ptr; cand carries one extra bit so the sum of
  // pointer and offset can be wrapped back into 0..NUM_PORT-1.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the combinational block would infer a latch.
    win   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < NUM_PORT; off++) begin
      cand = {1'b0, rr_ptr} + (GW+1)'(off);
      if (cand >= (GW+1)'(NUM_PORT)) cand = cand - (GW+1)'(NUM_PORT);
      if (!found && bus.req_valid[cand[GW-1:0]]) begin
        win   = cand[GW-1:0];
        found = 1'b1;
      end
    end
  end

  assign rr_next = (win == GW'(NUM_PORT - 1)) ? '0 : win + GW'(1);
`else
  // Fixed priority: scanning downwards leaves the lowest requester as winner.
  always_comb begin
    win = '0;
    for (int i = NUM_PORT - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) win = GW'(i);
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered memory-side outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      mem_valid_q <= 1'b0;
      mem_r0w1_q  <= 1'b0;
      // NOTE: the address/data holding registers are reset too, so the
      // next level never sees stale X values on the bus after reset.
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_ptr      <= '0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          // mem_ready is ignored here; only a pending request moves the FSM.
          if (any_req) begin
            state       <= BUSY;
            grant       <= win;
            mem_valid_q <= 1'b1;
            mem_r0w1_q  <= bus.req_r0w1[win];
            mem_addr_q  <= bus.req_addr[win];
            mem_wdata_q <= bus.req_wdata[win];
`ifdef MEM_ARB_ROUND_ROBIN_EN
            rr_ptr      <= rr_next;
`endif
          end
        end
        BUSY: begin
          // Other ports' requests and withdrawal by the owner are ignored:
          // the transaction always runs until mem_ready.
          if (bus.mem_ready) begin
            state       <= IDLE;
            mem_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_r0w1  = mem_r0w1_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // ---------------------------------------------------------------------------
  // Requester-side response: steered to the owner only while BUSY. Because
  // reset forces IDLE asynchronously, these drop to zero immediately on reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.req_ready = '0;
    bus.req_rdata = '0;
    if (state == BUSY) begin
      bus.req_rdata[grant] = bus.mem_rdata;
      bus.req_ready[grant] = bus.mem_ready;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed self-checking bench for mem_arbiter (default
// parameters). Inputs change and outputs are sampled around the falling clock
// edge, well away from the active rising edge. Expected arbitration order
// follows the build option MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;

  localparam int BW_ADDRESS = 32;
  localparam int BW_BLOCK   = 128;
  localparam int NUM_PORT   = 2;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_err;

  mem_arbiter_if #(
    .BW_ADDRESS(BW_ADDRESS),
    .BW_BLOCK  (BW_BLOCK),
    .NUM_PORT  (NUM_PORT)
  ) bus ();

  mem_arbiter #(
    .BW_ADDRESS(BW_ADDRESS),
    .BW_BLOCK  (BW_BLOCK),
    .NUM_PORT  (NUM_PORT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  logic [127:0] rd_a5;
  logic [127:0] wd_1;
  logic [127:0] wd_2;
  int           exp_port;
  logic [1:0]   exp_rdy;

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rd_a5         = {16{8'hA5}};
    wd_1          = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    wd_2          = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_r0w1  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    // Reset state
    cyc(); #1;
    check("rst_mem_valid", 128'(bus.mem_valid), 128'(0));
    check("rst_mem_r0w1",  128'(bus.mem_r0w1),  128'(0));
    check("rst_mem_addr",  128'(bus.mem_addr),  128'(0));
    check("rst_mem_wdata", bus.mem_wdata,       128'(0));
    check("rst_req_ready", 128'(bus.req_ready), 128'(0));
    check("rst_rdata0",    bus.req_rdata[0],    128'(0));
    check("rst_rdata1",    bus.req_rdata[1],    128'(0));
    rst_n = 1'b1;

    // Single read on port 1, mem_ready after three wait cycles
    cyc();
    bus.req_valid   = 2'b10;
    bus.req_addr[1] = 32'h0000_1040;
    #1 check("rd1_idle_valid", 128'(bus.mem_valid), 128'(0));
    cyc(); #1;
    check("rd1_mem_valid", 128'(bus.mem_valid), 128'(1));
    check("rd1_mem_addr",  128'(bus.mem_addr),  128'h1040);
    check("rd1_mem_r0w1",  128'(bus.mem_r0w1),  128'(0));
    check("rd1_no_ready",  128'(bus.req_ready), 128'(0));
    repeat (2) begin
      cyc(); #1;
      check("rd1_wait_valid", 128'(bus.mem_valid), 128'(1));
      check("rd1_wait_ready", 128'(bus.req_ready), 128'(0));
    end
    cyc();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd_a5;
    #1;
    check("rd1_ready",  128'(bus.req_ready), 128'b10);
    check("rd1_rdata1", bus.req_rdata[1],    rd_a5);
    check("rd1_rdata0", bus.req_rdata[0],    128'(0));
    cyc();
    bus.mem_ready = 1'b0;
    bus.req_valid = '0;
    #1;
    check("rd1_done_valid", 128'(bus.mem_valid), 128'(0));
    check("rd1_done_ready", 128'(bus.req_ready), 128'(0));

    // mem_ready while IDLE is ignored
    cyc();
    bus.mem_ready = 1'b1;
    #1;
    check("idle_mr_ready",  128'(bus.req_ready), 128'(0));
    check("idle_mr_rdata1", bus.req_rdata[1],    128'(0));
    cyc();
    bus.mem_ready = 1'b0;
    #1 check("idle_mr_valid", 128'(bus.mem_valid), 128'(0));
    cyc(); #1 check("idle_mr_still", 128'(bus.mem_valid), 128'(0));

    // Both ports request together and keep requesting
    cyc();
    bus.req_valid   = 2'b11;
    bus.req_r0w1    = 2'b00;
    bus.req_addr[0] = 32'h0000_0100;
    bus.req_addr[1] = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_port = i % 2;
`else
      exp_port = 0;
`endif
      exp_rdy = 2'b01 << exp_port;
      cyc(); #1;
      check("both_valid", 128'(bus.mem_valid), 128'(1));
      check("both_addr",  128'(bus.mem_addr),  (exp_port == 1) ? 128'h200 : 128'h100);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 128'(i + 1);
      #1;
      check("both_ready", 128'(bus.req_ready),     128'(exp_rdy));
      check("both_rdata", bus.req_rdata[exp_port], 128'(i + 1));
      cyc();
      bus.mem_ready = 1'b0;
      if (i == 3) bus.req_valid = '0;
      #1 check("both_gap", 128'(bus.mem_valid), 128'(0));
    end

    // Port 0 arrives while port 1 is being served, then withdraws mid-BUSY
    cyc();
    bus.req_valid   = 2'b10;
    bus.req_addr[1] = 32'h0000_0300;
    cyc(); #1 check("late_addr1", 128'(bus.mem_addr), 128'h300);
    cyc();
    bus.req_valid   = 2'b11;
    bus.req_addr[0] = 32'h0000_0400;
    bus.mem_rdata   = 128'h77;
    #1;
    check("late_hold_addr", 128'(bus.mem_addr),  128'h300);
    check("late_no_ready",  128'(bus.req_ready), 128'(0));
    check("late_rdata1",    bus.req_rdata[1],    128'h77);
    check("late_rdata0",    bus.req_rdata[0],    128'(0));
    cyc();
    bus.mem_ready = 1'b1;
    #1;
    check("late_addr_end", 128'(bus.mem_addr),  128'h300);
    check("late_ready1",   128'(bus.req_ready), 128'b10);
    cyc();
    bus.mem_ready = 1'b0;
    bus.req_valid = 2'b01;
    #1 check("late_gap", 128'(bus.mem_valid), 128'(0));
    cyc(); #1;
    check("late_valid0", 128'(bus.mem_valid), 128'(1));
    check("late_addr0",  128'(bus.mem_addr),  128'h400);
    bus.req_valid = '0;
    cyc(); #1;
    check("wd_hold_valid", 128'(bus.mem_valid), 128'(1));
    check("wd_hold_addr",  128'(bus.mem_addr),  128'h400);
    bus.mem_ready = 1'b1;
    #1 check("wd_ready0", 128'(bus.req_ready), 128'b01);
    cyc();
    bus.mem_ready = 1'b0;
    #1 check("wd_done", 128'(bus.mem_valid), 128'(0));

    // Port 1 write 0x80 then read 0x40 with req_valid held throughout
    cyc();
    bus.req_valid    = 2'b10;
    bus.req_r0w1[1]  = 1'b1;
    bus.req_addr[1]  = 32'h0000_0080;
    bus.req_wdata[1] = wd_1;
    cyc(); #1;
    check("wb_valid", 128'(bus.mem_valid), 128'(1));
    check("wb_r0w1",  128'(bus.mem_r0w1),  128'(1));
    check("wb_addr",  128'(bus.mem_addr),  128'h80);
    check("wb_wdata", bus.mem_wdata,       wd_1);
    bus.mem_ready = 1'b1;
    #1 check("wb_ready", 128'(bus.req_ready), 128'b10);
    cyc();
    bus.mem_ready   = 1'b0;
    bus.req_r0w1[1] = 1'b0;
    bus.req_addr[1] = 32'h0000_0040;
    #1 check("wb_gap", 128'(bus.mem_valid), 128'(0));
    cyc(); #1;
    check("rf_valid", 128'(bus.mem_valid), 128'(1));
    check("rf_r0w1",  128'(bus.mem_r0w1),  128'(0));
    check("rf_addr",  128'(bus.mem_addr),  128'h40);
    bus.mem_ready = 1'b1;
    #1 check("rf_ready", 128'(bus.req_ready), 128'b10);
    cyc();
    bus.mem_ready = 1'b0;
    bus.req_valid = '0;
    #1 check("rf_done", 128'(bus.mem_valid), 128'(0));

    // Reset in the middle of a BUSY transaction
    cyc();
    bus.req_valid    = 2'b01;
    bus.req_r0w1[0]  = 1'b1;
    bus.req_addr[0]  = 32'h0000_0500;
    bus.req_wdata[0] = wd_2;
    cyc(); #1;
    check("rb_valid", 128'(bus.mem_valid), 128'(1));
    check("rb_addr",  128'(bus.mem_addr),  128'h500);
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("rb_rst_valid", 128'(bus.mem_valid), 128'(0));
    check("rb_rst_addr",  128'(bus.mem_addr),  128'(0));
    check("rb_rst_r0w1",  128'(bus.mem_r0w1),  128'(0));
    check("rb_rst_wdata", bus.mem_wdata,       128'(0));
    check("rb_rst_ready", 128'(bus.req_ready), 128'(0));
    check("rb_rst_rdata", bus.req_rdata[0],    128'(0));
    bus.req_valid = '0;
    cyc();
    rst_n = 1'b1;
    #1 check("rb_post_ready", 128'(bus.req_ready), 128'(0));
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    check("rb_post_valid",  128'(bus.mem_valid), 128'(0));
    check("rb_post_ready2", 128'(bus.req_ready), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
